// File: rtl/dds_seq_pkg.sv
// Shared types, sizes and helpers for the DDS pulse sequencer.
`timescale 1ns/1ps
package dds_seq_pkg;

   localparam int NUM_CH   = 16;
   localparam int PERIOD_W = 16;
   localparam int WIDTH_W  = 8;
   localparam int SLOT_W   = $clog2(NUM_CH);

   typedef enum logic [2:0] {
      IDLE,
      IOUP,
      RAMP,
      PULSE,
      DONE
   } state_e;

   // Slots shorter than two cycles leave no room for a low phase, so they are widened.
   function automatic logic [PERIOD_W-1:0] eff_period(input logic [PERIOD_W-1:0] period);
      return (period < PERIOD_W'(2)) ? PERIOD_W'(2) : period;
   endfunction

   function automatic logic [PERIOD_W-1:0] clamp_width(input logic [PERIOD_W-1:0] period_eff,
                                                      input logic [WIDTH_W-1:0]  width);
      logic [PERIOD_W-1:0] w;
      w = PERIOD_W'(width);
      return (w < period_eff - PERIOD_W'(1)) ? w : period_eff - PERIOD_W'(1);
   endfunction

endpackage

// File: rtl/dds_seq_sync2.sv
// Two-flop synchronizer with asynchronous active-low reset.
`timescale 1ns/1ps
module dds_seq_sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/dds_pulse_seq.sv
// DDS pulse sequencer: io_update strobe, ramp wait on drover, then 16 timed trigger slots.
// Optional RAMP watchdog enabled by defining DDS_SEQ_DROVER_TIMEOUT_EN.
`timescale 1ns/1ps
module dds_pulse_seq
   import dds_seq_pkg::*;
#(
   parameter int IOUP_WIDTH   = 4,
   parameter int RAMP_TIMEOUT = 65535
) (
   input  logic                clk_500m,
   input  logic                rst_n,
   input  logic                cfg_valid,
   output logic                cfg_ready,
   input  logic [PERIOD_W-1:0] cfg_period,
   input  logic [WIDTH_W-1:0]  cfg_width,
   input  logic [NUM_CH-1:0]   cfg_mask,
   input  logic                start,
   input  logic                abort,
   input  logic                drover,
   output logic [NUM_CH-1:0]   triger_pulse,
   output logic                pulse_position,
   output logic                osk,
   output logic                drctl,
   output logic                io_update,
   output logic                busy,
   output logic                done,
   output logic                timeout_err
);

   localparam logic [3:0]        IOUP_LAST = 4'(IOUP_WIDTH - 1);
   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_CH - 1);

   state_e              state_q, state_d;
   logic                cfg_latched_q, cfg_latched_d;
   logic [PERIOD_W-1:0] period_q, period_d;
   logic [PERIOD_W-1:0] pulse_len_q, pulse_len_d;
   logic [NUM_CH-1:0]   mask_q, mask_d;
   logic [3:0]          ioup_cnt_q, ioup_cnt_d;
   logic [SLOT_W-1:0]   slot_q, slot_d;
   logic [PERIOD_W-1:0] cyc_q, cyc_d;
   logic                pos_q, pos_d;
   logic                drover_sync;
   logic                ramp_expired;

   dds_seq_sync2 u_drover_sync (
      .clk   (clk_500m),
      .rst_n (rst_n),
      .d     (drover),
      .q     (drover_sync)
   );

`ifdef DDS_SEQ_DROVER_TIMEOUT_EN
   localparam int RAMP_W = (RAMP_TIMEOUT > 1) ? $clog2(RAMP_TIMEOUT) : 1;
   localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_TIMEOUT - 1);

   logic [RAMP_W-1:0] ramp_cnt_q, ramp_cnt_d;
   logic              timeout_err_q, timeout_err_d;

   assign ramp_expired = (state_q == RAMP) && (ramp_cnt_q == RAMP_LAST);

   // The error flag survives DONE and IDLE and is only cleared by an accepted start or abort.
   always_comb begin
      ramp_cnt_d    = (state_q == RAMP) ? ramp_cnt_q + 1'b1 : '0;
      timeout_err_d = timeout_err_q;
      if (abort)
         timeout_err_d = 1'b0;
      else if (state_q == IDLE && start && cfg_latched_q)
         timeout_err_d = 1'b0;
      else if (ramp_expired && !drover_sync)
         timeout_err_d = 1'b1;
   end

   always_ff @(posedge clk_500m or negedge rst_n) begin
      if (!rst_n) begin
         ramp_cnt_q    <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         ramp_cnt_q    <= ramp_cnt_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign timeout_err = timeout_err_q;
`else
   assign ramp_expired = 1'b0;
   assign timeout_err  = 1'b0;
`endif

   always_comb begin
      state_d       = state_q;
      cfg_latched_d = cfg_latched_q;
      period_d      = period_q;
      pulse_len_d   = pulse_len_q;
      mask_d        = mask_q;
      ioup_cnt_d    = ioup_cnt_q;
      slot_d        = slot_q;
      cyc_d         = cyc_q;
      pos_d         = pos_q;

      case (state_q)
         IDLE: begin
            if (cfg_valid) begin
               cfg_latched_d = 1'b1;
               period_d      = eff_period(cfg_period);
               pulse_len_d   = clamp_width(eff_period(cfg_period), cfg_width);
               mask_d        = cfg_mask;
            end
            if (start && cfg_latched_q) begin
               state_d    = IOUP;
               ioup_cnt_d = '0;
               pos_d      = 1'b0;
            end
         end
         IOUP: begin
            if (ioup_cnt_q == IOUP_LAST)
               state_d = RAMP;
            else
               ioup_cnt_d = ioup_cnt_q + 1'b1;
         end
         RAMP: begin
            if (drover_sync) begin
               state_d = PULSE;
               slot_d  = '0;
               cyc_d   = '0;
               pos_d   = ~pos_q;
            end else if (ramp_expired) begin
               state_d = DONE;
            end
         end
         // Each slot toggles pulse_position on its first cycle; the last slot hands over to DONE.
         PULSE: begin
            if (cyc_q == period_q - PERIOD_W'(1)) begin
               cyc_d = '0;
               if (slot_q == SLOT_LAST) begin
                  state_d = DONE;
               end else begin
                  slot_d = slot_q + 1'b1;
                  pos_d  = ~pos_q;
               end
            end else begin
               cyc_d = cyc_q + PERIOD_W'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      if (abort) begin
         state_d    = IDLE;
         ioup_cnt_d = '0;
         slot_d     = '0;
         cyc_d      = '0;
         pos_d      = 1'b0;
      end
   end

   always_ff @(posedge clk_500m or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         cfg_latched_q <= 1'b0;
         period_q      <= PERIOD_W'(2);
         pulse_len_q   <= '0;
         mask_q        <= '0;
         ioup_cnt_q    <= '0;
         slot_q        <= '0;
         cyc_q         <= '0;
         pos_q         <= 1'b0;
      end else begin
         state_q       <= state_d;
         cfg_latched_q <= cfg_latched_d;
         period_q      <= period_d;
         pulse_len_q   <= pulse_len_d;
         mask_q        <= mask_d;
         ioup_cnt_q    <= ioup_cnt_d;
         slot_q        <= slot_d;
         cyc_q         <= cyc_d;
         pos_q         <= pos_d;
      end
   end

   // Outputs decode directly from state so an async reset clears them without waiting for a clock.
   assign cfg_ready      = (state_q == IDLE);
   assign busy           = (state_q != IDLE);
   assign done           = (state_q == DONE);
   assign io_update      = (state_q == IOUP);
   assign osk            = (state_q == IOUP) || (state_q == RAMP) || (state_q == PULSE);
   assign drctl          = (state_q == RAMP) || (state_q == PULSE);
   assign pulse_position = pos_q;
   assign triger_pulse   = (state_q == PULSE && cyc_q < pulse_len_q) ?
                           (mask_q & (NUM_CH'(1) << slot_q)) : '0;

endmodule
